// File: rtl/majority_sampler_mc.sv
`default_nettype none
// majority_sampler_mc: per-channel synchroniser, saturating high/low window counters and
// tick-driven majority vote (full window or last three samples) with noise/saturation flags.
module majority_sampler_mc #(
  parameter int CHANNELS    = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_VALUE  = 1'b1,
  parameter bit TIE_VALUE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic                sample_tick,
  input  logic                mode,
  output logic [CHANNELS-1:0] filtered,
  output logic                valid,
  output logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] saturated
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic valid_q;
  logic valid_d;

  always_comb begin
    valid_d = sample_tick;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;
      logic [CNT_W-1:0]       hi_q;
      logic [CNT_W-1:0]       hi_d;
      logic [CNT_W-1:0]       lo_q;
      logic [CNT_W-1:0]       lo_d;
      logic                   sat_q;
      logic                   sat_d;
      logic [2:0]             hist_q;
      logic [2:0]             hist_d;
      logic                   filt_q;
      logic                   filt_d;
      logic                   noisy_q;
      logic                   noisy_d;
      logic                   satf_q;
      logic                   satf_d;

      logic                   s;
      logic [CNT_W-1:0]       hi_n;
      logic [CNT_W-1:0]       lo_n;
      logic [2:0]             hist_n;
      logic                   sat_n;
      logic                   vote_win;
      logic                   vote_l3;

      always_comb begin
        // Shift towards the MSB; the cast drops the oldest stage.
        sync_d = SYNC_STAGES'({sync_q, sig_in[gi]});
        s      = sync_q[SYNC_STAGES-1];

        hi_n   = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_W'(s);
        lo_n   = (lo_q == CNT_MAX) ? lo_q : lo_q + CNT_W'(!s);
        hist_n = {hist_q[1:0], s};
        sat_n  = sat_q | (hi_n == CNT_MAX) | (lo_n == CNT_MAX);

        if (hi_n > lo_n) begin
          vote_win = 1'b1;
        end else if (hi_n < lo_n) begin
          vote_win = 1'b0;
        end else begin
          vote_win = TIE_VALUE;
        end
        vote_l3 = (hist_n[0] & hist_n[1]) | (hist_n[0] & hist_n[2]) | (hist_n[1] & hist_n[2]);

        hist_d  = hist_n;
        hi_d    = hi_n;
        lo_d    = lo_n;
        sat_d   = sat_n;
        filt_d  = filt_q;
        noisy_d = noisy_q;
        satf_d  = satf_q;

        // The tick cycle's own sample is part of the closing window.
        if (sample_tick) begin
          filt_d  = mode ? vote_l3 : vote_win;
          noisy_d = (hi_n != CNT_ZERO) && (lo_n != CNT_ZERO);
          satf_d  = sat_n;
          hi_d    = CNT_ZERO;
          lo_d    = CNT_ZERO;
          sat_d   = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q  <= {SYNC_STAGES{IDLE_VALUE}};
          hist_q  <= {3{IDLE_VALUE}};
          hi_q    <= CNT_ZERO;
          lo_q    <= CNT_ZERO;
          sat_q   <= 1'b0;
          filt_q  <= IDLE_VALUE;
          noisy_q <= 1'b0;
          satf_q  <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          hist_q  <= hist_d;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          sat_q   <= sat_d;
          filt_q  <= filt_d;
          noisy_q <= noisy_d;
          satf_q  <= satf_d;
        end
      end

      assign filtered[gi]  = filt_q;
      assign noisy[gi]     = noisy_q;
      assign saturated[gi] = satf_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_majority_sampler_mc.sv
`default_nettype none
// Bench for majority_sampler_mc: table of windows plus hand sequences, checked through a scoreboard.
module tb_majority_sampler_mc;

  localparam int CH = 2;
  localparam int CW = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig_in;
  logic          sample_tick;
  logic          mode;
  logic [CH-1:0] filtered;
  logic          valid;
  logic [CH-1:0] noisy;
  logic [CH-1:0] saturated;

  always #5 clk = ~clk;

  majority_sampler_mc #(
    .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .IDLE_VALUE(1'b1), .TIE_VALUE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .sample_tick(sample_tick), .mode(mode),
    .filtered(filtered), .valid(valid), .noisy(noisy), .saturated(saturated)
  );

  typedef struct packed {
    logic [1:0] f;
    logic [1:0] n;
    logic [1:0] s;
  } exp_t;

  typedef struct {
    bit          md;
    int          len;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [1:0]  ef;
    logic [1:0]  en;
    logic [1:0]  es;
  } vec_t;

  localparam exp_t RST_EXP = '{f: 2'b11, n: 2'b00, s: 2'b00};

  exp_t exp_q[$];
  exp_t held;
  logic exp_valid;
  logic rst_seen;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_valid <= sample_tick && rst;
    rst_seen  <= rst;
  end

  always @(negedge clk) begin
    chk("valid", {1'b0, valid}, {1'b0, exp_valid});
    if (!rst_seen) begin
      held = RST_EXP;
    end else if (exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard at %0t: got decision with no queued expectation, expected queued entry", $time);
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("filtered", filtered, held.f);
    chk("noisy", noisy, held.n);
    chk("saturated", saturated, held.s);
  end

  task automatic step(input logic r, input logic [1:0] s, input logic t, input logic m);
    @(negedge clk);
    rst         = r;
    sig_in      = s;
    sample_tick = t;
    mode        = m;
  endtask

  task automatic tstep(input logic [1:0] s, input logic m, input exp_t e);
    step(1'b1, s, 1'b1, m);
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] runs(input bit v0, input int n0, input bit v1, input int n1,
                                       input bit v2, input int n2);
    logic [63:0] p;
    int pos;
    p   = '0;
    pos = 0;
    for (int i = 0; i < n0; i++) begin p[pos] = v0; pos++; end
    for (int i = 0; i < n1; i++) begin p[pos] = v1; pos++; end
    for (int i = 0; i < n2; i++) begin p[pos] = v2; pos++; end
    return p;
  endfunction

  vec_t        tbl[11];
  logic [1:0]  sched_sig[256];
  bit          sched_tick[256];
  bit          sched_mode[256];
  int          sched_idx[256];

  initial begin
    logic [63:0] alt;
    int o;
    int total;
    int wait_cnt;

    alt = 64'h0000_0002_AAAA_AAAA;
    // The first window also holds the three idle samples flushed out of the synchroniser.
    tbl[0]  = '{1'b0, 13, runs(1,13,0,0,0,0), runs(1,13,0,0,0,0), 2'b11, 2'b00, 2'b11};
    tbl[1]  = '{1'b0, 16, runs(0,12,1,4,0,0), runs(1,8,0,8,0,0),  2'b10, 2'b11, 2'b00};
    tbl[2]  = '{1'b1, 16, runs(1,13,0,2,1,1), runs(0,13,1,2,0,1), 2'b10, 2'b11, 2'b00};
    tbl[3]  = '{1'b0, 16, runs(1,13,0,2,1,1), runs(0,13,1,2,0,1), 2'b01, 2'b11, 2'b00};
    tbl[4]  = '{1'b1, 2,  runs(0,1,1,1,0,0),  runs(0,1,1,1,0,0),  2'b01, 2'b11, 2'b00};
    tbl[5]  = '{1'b0, 1,  runs(0,1,0,0,0,0),  runs(1,1,0,0,0,0),  2'b10, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 1,  runs(1,1,0,0,0,0),  runs(0,1,0,0,0,0),  2'b01, 2'b00, 2'b00};
    tbl[7]  = '{1'b0, 40, runs(1,40,0,0,0,0), runs(0,40,0,0,0,0), 2'b01, 2'b00, 2'b11};
    tbl[8]  = '{1'b0, 10, runs(1,10,0,0,0,0), runs(0,5,1,5,0,0),  2'b11, 2'b10, 2'b00};
    tbl[9]  = '{1'b0, 34, runs(1,17,0,17,0,0), alt,                2'b11, 2'b11, 2'b11};
    tbl[10] = '{1'b1, 3,  runs(1,2,0,1,0,0),  runs(0,2,1,1,0,0),  2'b01, 2'b11, 2'b00};

    for (int c = 0; c < 256; c++) begin
      sched_sig[c]  = 2'b00;
      sched_tick[c] = 1'b0;
      sched_mode[c] = 1'b0;
      sched_idx[c]  = -1;
    end
    o = 0;
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < tbl[k].len; j++) begin
        sched_sig[o+j] = {tbl[k].p1[j], tbl[k].p0[j]};
      end
      sched_tick[o+tbl[k].len+SS-1] = 1'b1;
      sched_mode[o+tbl[k].len+SS-1] = tbl[k].md;
      sched_idx[o+tbl[k].len+SS-1]  = k;
      o += tbl[k].len;
    end
    total = o + SS;

    rst = 1'b0; sig_in = 2'b11; sample_tick = 1'b0; mode = 1'b0;
    repeat (3) step(1'b0, 2'b11, 1'b0, 1'b0);

    for (int c = 0; c < total; c++) begin
      step(1'b1, sched_sig[c], sched_tick[c], sched_mode[c]);
      if (sched_tick[c]) begin
        exp_q.push_back('{f: tbl[sched_idx[c]].ef, n: tbl[sched_idx[c]].en, s: tbl[sched_idx[c]].es});
      end
    end

    // Mid-window reset: stale highs must vanish; tick right after release votes on idle data.
    repeat (6) step(1'b1, 2'b11, 1'b0, 1'b0);
    repeat (2) step(1'b0, 2'b00, 1'b0, 1'b0);
    tstep(2'b00, 1'b0, '{f: 2'b11, n: 2'b00, s: 2'b00});
    step(1'b1, 2'b00, 1'b0, 1'b0);
    tstep(2'b00, 1'b0, '{f: 2'b11, n: 2'b00, s: 2'b00});
    repeat (4) step(1'b1, 2'b00, 1'b0, 1'b0);
    tstep(2'b00, 1'b0, '{f: 2'b00, n: 2'b00, s: 2'b00});

    // Synchroniser latency: step to 0, then one-sample windows at step+0..step+3.
    repeat (9) step(1'b1, 2'b11, 1'b0, 1'b0);
    tstep(2'b11, 1'b0, '{f: 2'b11, n: 2'b11, s: 2'b00});
    tstep(2'b00, 1'b0, '{f: 2'b11, n: 2'b00, s: 2'b00});
    tstep(2'b00, 1'b0, '{f: 2'b11, n: 2'b00, s: 2'b00});
    tstep(2'b00, 1'b0, '{f: 2'b11, n: 2'b00, s: 2'b00});
    tstep(2'b00, 1'b0, '{f: 2'b00, n: 2'b00, s: 2'b00});

    repeat (3) step(1'b1, 2'b00, 1'b0, 1'b0);
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d undelivered decisions, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
